lcd_text_refresh: RTL and testbench

- Upstream feeder for the LCD character-bus controller. Replaces the fixed message lookup table with a writable 32-character text buffer: 2 lines of 16 characters.
- After reset it runs the HD44780 init sequence, then writes the whole buffer to the display.
- After that it re-writes the display whenever the host has changed the buffer.
- It talks to the controller with the existing start/done handshake, using iStart, oDone, iDATA and iRS.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_text_buf.sv | 31 +++
 rtl/lcd_text_refresh.sv | 157 +++++++++++++++
 tb/tb_lcd_text_refresh.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Purpose: shared command codes, transfer-list step indices and sequencer states for the LCD text feeder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lcd_pkg;

    // HD44780 command bytes (sent with RS = 0)
    localparam logic [7:0] LCD_CLEAR      = 8'h01;
    localparam logic [7:0] LCD_ENTRY      = 8'h06;
    localparam logic [7:0] LCD_DISP_ON    = 8'h0C;
    localparam logic [7:0] LCD_LINE1_ADDR = 8'h80;
    localparam logic [7:0] LCD_LINE2_ADDR = 8'hC0;

    // Transfer-list step indices
    localparam logic [5:0] STEP_PASS_FIRST = 6'd4;   // line-1 address command, first step of a refresh pass
    localparam logic [5:0] STEP_LINE1      = 6'd5;   // first character of line 1
    localparam logic [5:0] STEP_CH_LINE    = 6'd21;  // line-2 address command
    localparam logic [5:0] STEP_LINE2      = 6'd22;  // first character of line 2
    localparam logic [5:0] STEP_LAST       = 6'd37;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_WAIT,
        ST_DLY,
        ST_NEXT,
        ST_IDLE
    } lcdState_t;

    // Buffer address of a character step. Steps 5-20 map to 0-15, steps 22-37 to 16-31.
    // The result is meaningless for command steps and is never used for them.
    function automatic logic [4:0] stepToAddr(input logic [5:0] step);
        return 5'((step < STEP_CH_LINE) ? (step - STEP_LINE1) : (step - STEP_LINE2 + 6'd16));
    endfunction

endpackage

// File: rtl/lcd_text_buf.sv
// Purpose: 32x8 character buffer, two lines of 16, cleared to spaces on reset.
// Latency: write lands on the next iCLK edge; read is combinational from the stored contents.
// Backpressure: none, a write is accepted every cycle.
// Ports: iCLK/iRST_N clock and async active-low reset; wrEn/wrAddr/wrData write port;
//        rdAddr/rdData combinational read port.
module lcd_text_buf (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       wrEn,
    input  logic [4:0] wrAddr,
    input  logic [7:0] wrData,
    input  logic [4:0] rdAddr,
    output logic [7:0] rdData
);

    logic [7:0] mem [32];

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 8'h20;
            end
        end else if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // A read in the same cycle as a write to the same entry returns the old byte.
    assign rdData = mem[rdAddr];

endmodule

// File: rtl/lcd_text_refresh.sv
// Purpose: feeds the LCD character-bus controller: HD44780 init once, then re-sends the 2x16 text buffer whenever it changes.
// Latency: a host write seen in IDLE raises oStart with 0x80 two cycles after the write lands (IDLE, then LOAD).
// Backpressure: none toward the host; toward the controller each byte waits on iDone plus a fixed idle gap.
// Ports: iCLK/iRST_N clock and async active-low reset; iWR/iADDR/iCHAR host character writes;
//        oDATA/oRS/oStart/iDone controller start/done handshake; oInitDone sticky init-finished flag;
//        oBusy high while a refresh pass is in progress.
module lcd_text_refresh
    import lcd_pkg::*;
#(
    parameter int unsigned DLY_CYCLES     = 262142,
    parameter int unsigned CLR_DLY_CYCLES = 262142,
    parameter logic [7:0]  FN_SET         = 8'h38
) (
    input  logic       iCLK,
    input  logic       iRST_N,
    input  logic       iWR,
    input  logic [4:0] iADDR,
    input  logic [7:0] iCHAR,
    output logic [7:0] oDATA,
    output logic       oRS,
    output logic       oStart,
    input  logic       iDone,
    output logic       oInitDone,
    output logic       oBusy
);

    localparam int CNT_W = $clog2(CLR_DLY_CYCLES + 1);
    // The DLY state lasts exactly N cycles: the counter runs 0..N-1.
    localparam logic [CNT_W-1:0] DLY_TERM = CNT_W'(DLY_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLR_TERM = CNT_W'(CLR_DLY_CYCLES - 1);

    lcdState_t        state, stateNxt;
    logic [5:0]       step, stepNxt;
    logic [CNT_W-1:0] dlyCnt, dlyCntNxt;
    logic             dirty, dirtyClr;
    logic [7:0]       dataNxt;
    logic             rsNxt, startNxt, initDoneNxt, busyNxt;

    logic [7:0]       rdChar;
    logic [7:0]       stepData;
    logic             stepRs;
    logic [CNT_W-1:0] dlyTerm;

    lcd_text_buf u_buf (
        .iCLK   (iCLK),
        .iRST_N (iRST_N),
        .wrEn   (iWR),
        .wrAddr (iADDR),
        .wrData (iCHAR),
        .rdAddr (stepToAddr(step)),
        .rdData (rdChar)
    );

    // Byte and RS for the current step of the transfer list
    always_comb begin
        stepData = rdChar;
        stepRs   = 1'b1;
        case (step)
            6'd0:            begin stepData = FN_SET;         stepRs = 1'b0; end
            6'd1:            begin stepData = LCD_DISP_ON;    stepRs = 1'b0; end
            6'd2:            begin stepData = LCD_CLEAR;      stepRs = 1'b0; end
            6'd3:            begin stepData = LCD_ENTRY;      stepRs = 1'b0; end
            STEP_PASS_FIRST: begin stepData = LCD_LINE1_ADDR; stepRs = 1'b0; end
            STEP_CH_LINE:    begin stepData = LCD_LINE2_ADDR; stepRs = 1'b0; end
            default:         ;
        endcase
    end

    // oDATA/oRS still hold the byte just sent, so they pick the gap length.
    assign dlyTerm = (oDATA == LCD_CLEAR && !oRS) ? CLR_TERM : DLY_TERM;

    always_comb begin
        stateNxt    = state;
        stepNxt     = step;
        dlyCntNxt   = dlyCnt;
        dataNxt     = oDATA;
        rsNxt       = oRS;
        startNxt    = oStart;
        initDoneNxt = oInitDone;
        busyNxt     = oBusy;
        dirtyClr    = 1'b0;
        case (state)
            ST_LOAD: begin
                dataNxt  = stepData;
                rsNxt    = stepRs;
                startNxt = 1'b1;
                busyNxt  = 1'b1;
                stateNxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (iDone) begin
                    startNxt = 1'b0;
                    stateNxt = ST_DLY;
                end
            end
            ST_DLY: begin
                if (dlyCnt == dlyTerm) begin
                    dlyCntNxt = '0;
                    stateNxt  = ST_NEXT;
                end else begin
                    dlyCntNxt = dlyCnt + 1'b1;
                end
            end
            ST_NEXT: begin
                if (step == STEP_LAST) begin
                    initDoneNxt = 1'b1;
                    busyNxt     = 1'b0;
                    if (dirty) begin
                        dirtyClr = 1'b1;
                        stepNxt  = STEP_PASS_FIRST;
                        stateNxt = ST_LOAD;
                    end else begin
                        stateNxt = ST_IDLE;
                    end
                end else begin
                    stepNxt  = step + 1'b1;
                    stateNxt = ST_LOAD;
                end
            end
            ST_IDLE: begin
                busyNxt = 1'b0;
                if (dirty) begin
                    dirtyClr = 1'b1;
                    stepNxt  = STEP_PASS_FIRST;
                    stateNxt = ST_LOAD;
                end
            end
            default: stateNxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= ST_LOAD;
            step      <= '0;
            dlyCnt    <= '0;
            dirty     <= 1'b0;
            oDATA     <= '0;
            oRS       <= 1'b0;
            oStart    <= 1'b0;
            oInitDone <= 1'b0;
            oBusy     <= 1'b0;
        end else begin
            state     <= stateNxt;
            step      <= stepNxt;
            dlyCnt    <= dlyCntNxt;
            // A write in the same cycle as the clear keeps dirty set.
            dirty     <= iWR | (dirty & ~dirtyClr);
            oDATA     <= dataNxt;
            oRS       <= rsNxt;
            oStart    <= startNxt;
            oInitDone <= initDoneNxt;
            oBusy     <= busyNxt;
        end
    end

endmodule

// File: tb/tb_lcd_text_refresh.sv
module tb_lcd_text_refresh;

    localparam int DLY = 4;
    localparam int CLR = 8;

    logic       iCLK = 1'b0;
    logic       iRST_N;
    logic       iWR;
    logic [4:0] iADDR;
    logic [7:0] iCHAR;
    logic [7:0] oDATA;
    logic       oRS;
    logic       oStart;
    logic       iDone;
    logic       oInitDone;
    logic       oBusy;

    lcd_text_refresh #(
        .DLY_CYCLES     (DLY),
        .CLR_DLY_CYCLES (CLR),
        .FN_SET         (8'h38)
    ) dut (
        .iCLK      (iCLK),
        .iRST_N    (iRST_N),
        .iWR       (iWR),
        .iADDR     (iADDR),
        .iCHAR     (iCHAR),
        .oDATA     (oDATA),
        .oRS       (oRS),
        .oStart    (oStart),
        .iDone     (iDone),
        .oInitDone (oInitDone),
        .oBusy     (oBusy)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [7:0] data;
        logic       rs;
        int         gap;   // expected low cycles of oStart before this transfer, -1 = not checked
    } xfer_t;

    xfer_t      expQ[$];
    logic [7:0] model [32];
    int         checks = 0;
    int         errors = 0;
    int         txCount = 0;
    bit         doneTied = 1'b0;
    bit         prevStart = 1'b0;
    int         lowCnt = 0;
    int         highCnt = 0;

    // Controller model: done 3 cycles after start rises, or permanently high when tied.
    assign iDone = doneTied || (highCnt >= 3);

    // Transfer monitor, sampled 1 time unit after each rising clock edge.
    always @(posedge iCLK) begin
        #1;
        if (!iRST_N) begin
            prevStart = 1'b0;
            lowCnt    = 0;
            highCnt   = 0;
        end else begin
            if (oStart && !prevStart) begin
                checks++;
                assert (expQ.size() != 0) else begin
                    errors++;
                    $error("FAIL unexpected_xfer: got data %h rs %0b, expected no transfer", oDATA, oRS);
                end
                if (expQ.size() != 0) begin
                    xfer_t e;
                    e = expQ.pop_front();
                    checks++;
                    assert (oDATA === e.data) else begin
                        errors++;
                        $error("FAIL xfer_data #%0d: got %h expected %h", txCount, oDATA, e.data);
                    end
                    checks++;
                    assert (oRS === e.rs) else begin
                        errors++;
                        $error("FAIL xfer_rs #%0d: got %0b expected %0b", txCount, oRS, e.rs);
                    end
                    if (e.gap >= 0) begin
                        checks++;
                        assert (lowCnt == e.gap) else begin
                            errors++;
                            $error("FAIL xfer_gap #%0d: got %0d expected %0d", txCount, lowCnt, e.gap);
                        end
                    end
                end
                txCount++;
            end
            if (!oStart && prevStart) begin
                checks++;
                assert (highCnt == (doneTied ? 1 : 3)) else begin
                    errors++;
                    $error("FAIL start_width: got %0d expected %0d", highCnt, doneTied ? 1 : 3);
                end
            end
            if (oStart) begin
                highCnt++;
                lowCnt = 0;
            end else begin
                highCnt = 0;
                lowCnt++;
            end
            prevStart = oStart;
        end
    end

    // Expected transfers for one pass, built from the bench's own copy of the buffer.
    // NEXT and LOAD add two low cycles on top of each idle delay.
    task automatic pushPass(input bit withInit);
        xfer_t e;
        bit    prevClr;
        int    first;
        first   = withInit ? 0 : 4;
        prevClr = 1'b0;
        for (int s = first; s <= 37; s++) begin
            e.rs = 1'b0;
            case (s)
                0:  e.data = 8'h38;
                1:  e.data = 8'h0C;
                2:  e.data = 8'h01;
                3:  e.data = 8'h06;
                4:  e.data = 8'h80;
                21: e.data = 8'hC0;
                default: begin
                    e.rs   = 1'b1;
                    e.data = (s < 21) ? model[s - 5] : model[s - 6];
                end
            endcase
            e.gap   = (s == first) ? -1 : (prevClr ? CLR + 2 : DLY + 2);
            prevClr = (e.data == 8'h01) && !e.rs;
            expQ.push_back(e);
        end
    endtask

    // Called just after a falling edge; the write is sampled on the next rising edge.
    task automatic wr(input logic [4:0] a, input logic [7:0] c);
        iWR   = 1'b1;
        iADDR = a;
        iCHAR = c;
        model[a] = c;
        @(negedge iCLK);
        iWR = 1'b0;
    endtask

    task automatic check1(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        while (!(expQ.size() == 0 && !oBusy && !oStart) && n < 3000) begin
            @(negedge iCLK);
            n++;
        end
        checks++;
        assert (expQ.size() == 0 && !oBusy && !oStart) else begin
            errors++;
            $error("FAIL %s_drain: %0d transfers still expected, busy %0b", tag, expQ.size(), oBusy);
        end
        // Quiet period: the monitor flags any extra transfer here.
        repeat (60) @(negedge iCLK);
        check1({tag, "_quiet_start"}, {7'd0, oStart}, 8'd0);
    endtask

    task automatic waitTx(input int target, input string tag);
        int n = 0;
        while (txCount < target && n < 3000) begin
            @(negedge iCLK);
            n++;
        end
        checks++;
        assert (txCount >= target) else begin
            errors++;
            $error("FAIL %s_wait_tx: got %0d transfers expected %0d", tag, txCount, target);
        end
    endtask

    initial begin
        int base;
        int n;
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        iRST_N = 1'b0;
        iWR    = 1'b0;
        iADDR  = '0;
        iCHAR  = '0;

        // Reset state
        repeat (3) @(negedge iCLK);
        check1("rst_data",     oDATA,              8'h00);
        check1("rst_rs",       {7'd0, oRS},        8'd0);
        check1("rst_start",    {7'd0, oStart},     8'd0);
        check1("rst_initdone", {7'd0, oInitDone},  8'd0);
        check1("rst_busy",     {7'd0, oBusy},      8'd0);

        // Init plus first full refresh: 38 transfers
        pushPass(1'b1);
        iRST_N = 1'b1;
        waitDrain("init");
        check1("init_done", {7'd0, oInitDone}, 8'd1);
        check1("init_busy", {7'd0, oBusy},     8'd0);

        // Two writes from IDLE. The second lands in the cycle IDLE clears dirty,
        // so dirty stays set and an identical follow-up pass runs.
        wr(5'd0, 8'h48);
        wr(5'd31, 8'h21);
        pushPass(1'b0);
        pushPass(1'b0);
        check1("idle_lat_low", {7'd0, oStart}, 8'd0);
        @(negedge iCLK);
        check1("idle_lat_start", {7'd0, oStart}, 8'd1);
        check1("idle_lat_data",  oDATA,          8'h80);
        check1("idle_busy",      {7'd0, oBusy},  8'd1);
        waitDrain("idle_wr");

        // Write addr 3 while step 10 is in flight: one more pass with the new byte at step 8
        base = txCount;
        wr(5'd2, 8'h33);
        pushPass(1'b0);
        waitTx(base + 7, "mid_pass");
        wr(5'd3, 8'h5A);
        pushPass(1'b0);
        waitDrain("mid_pass");

        // Write addr 5 in the LOAD cycle of step 10: old byte now, new byte next pass
        base = txCount;
        wr(5'd1, 8'h42);
        pushPass(1'b0);
        waitTx(base + 6, "load_wr");
        n = 0;
        while (oStart && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        repeat (5) @(negedge iCLK);   // DLY x4, NEXT, now in LOAD of step 10
        wr(5'd5, 8'h41);
        check1("load_wr_start", {7'd0, oStart}, 8'd1);
        check1("load_wr_old",   oDATA,          8'h20);
        pushPass(1'b0);
        waitDrain("load_wr");

        // iDone held high: one-cycle starts, gaps unchanged
        doneTied = 1'b1;
        wr(5'd6, 8'h4B);
        pushPass(1'b0);
        waitDrain("done_tied");
        doneTied = 1'b0;

        // Reset while waiting on the controller
        wr(5'd7, 8'h4C);
        pushPass(1'b0);
        n = 0;
        while (!oStart && n < 50) begin
            @(negedge iCLK);
            n++;
        end
        check1("pre_rst_start", {7'd0, oStart}, 8'd1);
        iRST_N = 1'b0;
        #1;
        check1("async_rst_start", {7'd0, oStart},    8'd0);
        check1("async_rst_init",  {7'd0, oInitDone}, 8'd0);
        check1("async_rst_busy",  {7'd0, oBusy},     8'd0);
        expQ.delete();
        for (int i = 0; i < 32; i++) model[i] = 8'h20;
        @(negedge iCLK);
        @(negedge iCLK);
        pushPass(1'b1);
        iRST_N = 1'b1;
        waitDrain("re_init");
        check1("re_init_done", {7'd0, oInitDone}, 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d transfers still expected", expQ.size());
        $fatal(1, "watchdog expired");
    end

endmodule
